// File: rtl/gray_frame_ctrl_if.sv
// Bus bundle between the gray frame sequencer and its surroundings
// (control, source BRAM read port, converter, gray BRAM write port).
//   master : the sequencer (drives reads, converter feed, writes, status)
//   slave  : the environment (drives start/pause, read data, converter results)
interface gray_frame_ctrl_if #(
  parameter int unsigned ADDR_W = 17
);
  logic              start;
  logic              pause;
  logic              busy;
  logic              done;
  logic              timeout;
  logic              src_rd_en;
  logic [ADDR_W-1:0] src_rd_addr;
  logic [11:0]       src_rd_data;
  logic [11:0]       cvt_rgb;
  logic              cvt_en;
  logic [7:0]        cvt_gray;
  logic              cvt_gray_en;
  logic              dst_wr_en;
  logic [ADDR_W-1:0] dst_wr_addr;
  logic [7:0]        dst_wr_data;
  logic [15:0]       frame_cnt;

  modport master (
    input  start, pause, src_rd_data, cvt_gray, cvt_gray_en,
    output busy, done, timeout, src_rd_en, src_rd_addr, cvt_rgb, cvt_en,
           dst_wr_en, dst_wr_addr, dst_wr_data, frame_cnt
  );

  modport slave (
    output start, pause, src_rd_data, cvt_gray, cvt_gray_en,
    input  busy, done, timeout, src_rd_en, src_rd_addr, cvt_rgb, cvt_en,
           dst_wr_en, dst_wr_addr, dst_wr_data, frame_cnt
  );
endinterface

// File: rtl/gray_frame_ctrl.sv
// Frame sequencer for the RGB444-to-gray converter.
// On start it reads H_RES*V_RES pixels from the source BRAM, feeds them to the
// converter, and writes the converter results in order to the gray BRAM.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : gray_frame_ctrl_if.master
//          start/pause in, busy/done/timeout/frame_cnt status out,
//          src_rd_* source read port, cvt_* converter feed/result,
//          dst_wr_* gray write port (all write outputs registered)
module gray_frame_ctrl #(
  parameter int unsigned H_RES    = 320,
  parameter int unsigned V_RES    = 240,
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned DRAIN_TO = 8
) (
  input logic               clk,
  input logic               rst,
  gray_frame_ctrl_if.master bus
);

  localparam int unsigned       NPix      = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(NPix - 1);
  localparam logic [ADDR_W-1:0] PixCnt    = ADDR_W'(NPix);
  localparam int unsigned       DrainW    = (DRAIN_TO > 1) ? $clog2(DRAIN_TO) : 1;
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_TO - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d, rd_base;
  logic              src_rd_en_q, src_rd_en_d;
  logic [ADDR_W-1:0] src_rd_addr_q, src_rd_addr_d;
  logic              cvt_en_q;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic              dst_wr_en_q, dst_wr_en_d;
  logic [ADDR_W-1:0] dst_wr_addr_q, dst_wr_addr_d;
  logic [7:0]        dst_wr_data_q, dst_wr_data_d;
  logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
  logic              timeout_q, timeout_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              busy, done;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      // Leave RUN once the last read is on the bus.
      StRun:   if (src_rd_en_q && (src_rd_addr_q == LastAddr)) state_d = StDrain;
      StDrain: if ((wr_cnt_q == PixCnt) || (drain_cnt_q == DrainLast)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == StRun) || (state_q == StDrain);
    done = (state_q == StDone);
  end

  // Datapath next state
  always_comb begin
    rd_cnt_d      = rd_cnt_q;
    rd_base       = rd_cnt_q;
    src_rd_en_d   = 1'b0;
    src_rd_addr_d = src_rd_addr_q;
    wr_cnt_d      = wr_cnt_q;
    dst_wr_en_d   = 1'b0;
    dst_wr_addr_d = dst_wr_addr_q;
    dst_wr_data_d = dst_wr_data_q;
    drain_cnt_d   = '0;
    timeout_d     = timeout_q;
    frame_cnt_d   = frame_cnt_q;

    if ((state_q == StIdle) && bus.start) begin
      rd_base   = '0;
      rd_cnt_d  = '0;
      wr_cnt_d  = '0;
      timeout_d = 1'b0;
    end

    // Reads are registered, so the issue decision uses the state being entered;
    // this puts read 0 on the bus the cycle after start.
    if ((state_d == StRun) && !bus.pause && (rd_base != PixCnt)) begin
      src_rd_en_d   = 1'b1;
      src_rd_addr_d = rd_base;
      rd_cnt_d      = rd_base + ADDR_W'(1);
    end

    // Results beyond N or outside an active frame are dropped.
    if (((state_q == StRun) || (state_q == StDrain)) && bus.cvt_gray_en &&
        (wr_cnt_q != PixCnt)) begin
      dst_wr_en_d   = 1'b1;
      dst_wr_addr_d = wr_cnt_q;
      dst_wr_data_d = bus.cvt_gray;
      wr_cnt_d      = wr_cnt_q + ADDR_W'(1);
    end

    if (state_q == StDrain) begin
      drain_cnt_d = drain_cnt_q + DrainW'(1);
      if ((wr_cnt_q != PixCnt) && (drain_cnt_q == DrainLast)) begin
        timeout_d = 1'b1;
      end
    end

    if (state_q == StDone) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q      <= '0;
      src_rd_en_q   <= 1'b0;
      src_rd_addr_q <= '0;
      cvt_en_q      <= 1'b0;
      wr_cnt_q      <= '0;
      dst_wr_en_q   <= 1'b0;
      dst_wr_addr_q <= '0;
      dst_wr_data_q <= '0;
      drain_cnt_q   <= '0;
      timeout_q     <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      rd_cnt_q      <= rd_cnt_d;
      src_rd_en_q   <= src_rd_en_d;
      src_rd_addr_q <= src_rd_addr_d;
      cvt_en_q      <= src_rd_en_q;
      wr_cnt_q      <= wr_cnt_d;
      dst_wr_en_q   <= dst_wr_en_d;
      dst_wr_addr_q <= dst_wr_addr_d;
      dst_wr_data_q <= dst_wr_data_d;
      drain_cnt_q   <= drain_cnt_d;
      timeout_q     <= timeout_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.timeout     = timeout_q;
  assign bus.src_rd_en   = src_rd_en_q;
  assign bus.src_rd_addr = src_rd_addr_q;
  assign bus.cvt_en      = cvt_en_q;
  // BRAM data lands one cycle after the read, aligned with cvt_en; gate it so
  // the converter input is quiet between pixels and in reset.
  assign bus.cvt_rgb     = cvt_en_q ? bus.src_rd_data : 12'h000;
  assign bus.dst_wr_en   = dst_wr_en_q;
  assign bus.dst_wr_addr = dst_wr_addr_q;
  assign bus.dst_wr_data = dst_wr_data_q;
  assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_gray_frame_ctrl.sv
module tb_gray_frame_ctrl;
  localparam int unsigned AW = 17;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gray_frame_ctrl_if #(.ADDR_W(AW)) bus ();

  gray_frame_ctrl #(
    .H_RES(4), .V_RES(2), .ADDR_W(AW), .DRAIN_TO(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [11:0] seed      = 12'h0a5;
  logic        drop_last = 1'b0;

  function automatic logic [11:0] pix(input logic [AW-1:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'd397 + 32'(seed);
    return t[11:0];
  endfunction

  function automatic logic [7:0] gray(input logic [11:0] rgb);
    return 8'(rgb[11:8]) * 8'd5 + 8'(rgb[7:4]) * 8'd9 + 8'(rgb[3:0]) * 8'd2;
  endfunction

  // Source BRAM: one-cycle read latency
  logic [11:0] src_q = '0;
  always @(posedge clk) if (bus.src_rd_en) src_q <= pix(bus.src_rd_addr);
  assign bus.src_rd_data = src_q;

  // Converter: two-cycle latency, optionally drops the last pixel of a frame
  int         cv_cnt = 0;
  logic       c1_en = 1'b0, c2_en = 1'b0;
  logic [7:0] c1_g = '0, c2_g = '0;
  always @(posedge clk) begin
    if (bus.start && !bus.busy) cv_cnt <= 0;
    else if (bus.cvt_en) cv_cnt <= cv_cnt + 1;
    c1_en <= bus.cvt_en && !(drop_last && cv_cnt == 7);
    c1_g  <= gray(bus.cvt_rgb);
    c2_en <= c1_en;
    c2_g  <= c1_g;
  end
  assign bus.cvt_gray_en = c2_en;
  assign bus.cvt_gray    = c2_g;

  logic [75:0] outs;
  assign outs = {bus.busy, bus.done, bus.timeout, bus.src_rd_en, bus.src_rd_addr, bus.cvt_en,
                 bus.cvt_rgb, bus.dst_wr_en, bus.dst_wr_addr, bus.dst_wr_data, bus.frame_cnt};

  int checks = 0, errors = 0;
  int rel, n_rd, n_wr, n_done, done_cyc, first_wr, last_wr, busy_first, busy_last, busy_n;
  int          rd_cyc[$];
  int          exp_addr_q[$];
  logic [7:0]  exp_data_q[$];
  logic [11:0] exp_rgb_q[$];
  logic [15:0] exp_frames = '0;

  task automatic clear_logs();
    rel = 0; n_rd = 0; n_wr = 0; n_done = 0; done_cyc = -1;
    first_wr = -1; last_wr = -1; busy_first = -1; busy_last = -1; busy_n = 0;
    rd_cyc.delete(); exp_addr_q.delete(); exp_data_q.delete(); exp_rgb_q.delete();
  endtask

  // One cycle: sample at the falling edge, push expectations on reads,
  // pop and compare on converter feed and gray writes.
  task automatic step();
    int ea;
    logic [7:0] ed;
    logic [11:0] er;
    @(negedge clk);
    rel++;
    if (bus.src_rd_en) begin
      checks++;
      if (bus.src_rd_addr !== AW'(n_rd)) begin
        errors++;
        $display("FAIL rd_order: cycle %0d addr %0d, expected %0d", rel, bus.src_rd_addr, n_rd);
      end
      rd_cyc.push_back(rel);
      exp_addr_q.push_back(int'(bus.src_rd_addr));
      exp_rgb_q.push_back(pix(bus.src_rd_addr));
      exp_data_q.push_back(gray(pix(bus.src_rd_addr)));
      n_rd++;
    end
    if (bus.cvt_en) begin
      checks++;
      if (exp_rgb_q.size() == 0) begin
        errors++;
        $display("FAIL cvt_extra: cycle %0d rgb %h, expected no pixel", rel, bus.cvt_rgb);
      end else begin
        er = exp_rgb_q.pop_front();
        if (bus.cvt_rgb !== er) begin
          errors++;
          $display("FAIL cvt_rgb: cycle %0d got %h, expected %h", rel, bus.cvt_rgb, er);
        end
      end
    end
    if (bus.dst_wr_en) begin
      n_wr++;
      if (first_wr < 0) first_wr = rel;
      last_wr = rel;
      checks++;
      if (exp_addr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_extra: cycle %0d addr %0d data %h, expected no write",
                 rel, bus.dst_wr_addr, bus.dst_wr_data);
      end else begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        if (bus.dst_wr_addr !== AW'(ea) || bus.dst_wr_data !== ed) begin
          errors++;
          $display("FAIL wr_data: cycle %0d got addr %0d data %h, expected addr %0d data %h",
                   rel, bus.dst_wr_addr, bus.dst_wr_data, ea, ed);
        end
      end
    end
    if (bus.busy) begin
      if (busy_first < 0) busy_first = rel;
      busy_last = rel;
      busy_n++;
    end
    if (bus.done) begin
      n_done++;
      done_cyc = rel;
    end
  endtask

  // Start at cycle 0, drive pause over [p_lo,p_hi] and a second start at rs_at.
  task automatic run_frame(input int p_lo, input int p_hi, input int rs_at);
    clear_logs();
    bus.start = 1'b1;
    bus.pause = 1'b0;
    while (n_done == 0 && rel < 60) begin
      step();
      bus.start = (rel == rs_at);
      bus.pause = (rel >= p_lo && rel <= p_hi);
    end
    bus.start = 1'b0;
    bus.pause = 1'b0;
    exp_frames++;
    checks++;
    if (n_done == 0) begin
      errors++;
      $display("FAIL done_missing: no done within %0d cycles, expected one", rel);
    end
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    #2;
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outs: got %h, expected 0", outs);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_frame(100, 0, -1);
    checks++;
    if (n_rd != 8) begin errors++; $display("FAIL basic_nrd: got %0d, expected 8", n_rd); end
    for (int i = 0; i < rd_cyc.size() && i < 8; i++) begin
      checks++;
      if (rd_cyc[i] != 1 + i) begin
        errors++;
        $display("FAIL basic_rd_cyc: read %0d at cycle %0d, expected %0d", i, rd_cyc[i], 1 + i);
      end
    end
    checks++;
    if (n_wr != 8 || first_wr != 5 || last_wr != 12) begin
      errors++;
      $display("FAIL basic_wr: got %0d writes cycles %0d..%0d, expected 8 writes 5..12",
               n_wr, first_wr, last_wr);
    end
    checks++;
    if (n_done != 1 || done_cyc != 13) begin
      errors++;
      $display("FAIL basic_done: got %0d pulses at %0d, expected 1 at 13", n_done, done_cyc);
    end
    checks++;
    if (busy_first != 1 || busy_last != 12 || busy_n != 12) begin
      errors++;
      $display("FAIL basic_busy: got %0d..%0d (%0d), expected 1..12 (12)",
               busy_first, busy_last, busy_n);
    end
    checks++;
    if (bus.frame_cnt !== exp_frames || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL basic_status: frame_cnt %0d timeout %0b, expected %0d 0",
               bus.frame_cnt, bus.timeout, exp_frames);
    end
  endtask

  task automatic test_pause();
    int stalled;
    seed = 12'h3c1;
    run_frame(3, 5, -1);
    stalled = 0;
    foreach (rd_cyc[i]) if (rd_cyc[i] >= 4 && rd_cyc[i] <= 5) stalled++;
    checks++;
    if (stalled != 0 || n_rd != 8) begin
      errors++;
      $display("FAIL pause_reads: got %0d reads, %0d during pause, expected 8, 0", n_rd, stalled);
    end
    checks++;
    if (n_wr != 8 || exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL pause_writes: got %0d writes, %0d pending, expected 8, 0",
               n_wr, exp_addr_q.size());
    end
    checks++;
    if (done_cyc != 16) begin
      errors++;
      $display("FAIL pause_done: got cycle %0d, expected 16", done_cyc);
    end
  endtask

  task automatic test_restart_ignored();
    seed = 12'h777;
    run_frame(100, 0, 6);
    repeat (6) step();
    checks++;
    if (n_wr != 8 || n_done != 1 || busy_last != 12) begin
      errors++;
      $display("FAIL restart: got %0d writes %0d done busy_last %0d, expected 8 1 12",
               n_wr, n_done, busy_last);
    end
    checks++;
    if (bus.frame_cnt !== exp_frames) begin
      errors++;
      $display("FAIL restart_frames: got %0d, expected %0d", bus.frame_cnt, exp_frames);
    end
  endtask

  task automatic test_timeout();
    seed = 12'h111;
    drop_last = 1'b1;
    run_frame(100, 0, -1);
    drop_last = 1'b0;
    checks++;
    if (bus.timeout !== 1'b1 || n_done != 1) begin
      errors++;
      $display("FAIL timeout_set: got timeout %0b done %0d, expected 1 1", bus.timeout, n_done);
    end
    checks++;
    if (n_wr != 7 || exp_addr_q.size() != 1) begin
      errors++;
      $display("FAIL timeout_writes: got %0d writes %0d pending, expected 7 1",
               n_wr, exp_addr_q.size());
    end
    checks++;
    if (bus.frame_cnt !== exp_frames) begin
      errors++;
      $display("FAIL timeout_frames: got %0d, expected %0d", bus.frame_cnt, exp_frames);
    end
    clear_logs();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got %0b, expected 0", bus.timeout);
    end
    while (n_done == 0 && rel < 60) step();
    exp_frames++;
    step();
    checks++;
    if (n_wr != 8 || bus.timeout !== 1'b0 || n_done != 1) begin
      errors++;
      $display("FAIL timeout_recover: got %0d writes timeout %0b done %0d, expected 8 0 1",
               n_wr, bus.timeout, n_done);
    end
  endtask

  task automatic test_reset_mid();
    seed = 12'h5e2;
    clear_logs();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    while (rel < 7) step();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_mid_outs: got %h, expected 0", outs);
    end
    #1 rst = 1'b0;
    exp_frames = '0;
    clear_logs();
    repeat (8) step();
    checks++;
    if (n_wr != 0 || busy_n != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: got %0d writes %0d busy cycles, expected 0 0", n_wr, busy_n);
    end
    run_frame(100, 0, -1);
    checks++;
    if (n_wr != 8 || done_cyc != 13 || bus.frame_cnt !== exp_frames) begin
      errors++;
      $display("FAIL reset_mid_rerun: got %0d writes done %0d frames %0d, expected 8 13 %0d",
               n_wr, done_cyc, bus.frame_cnt, exp_frames);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.frame_cnt_q = 16'hffff;
    #1 release dut.frame_cnt_q;
    exp_frames = 16'hffff;
    run_frame(100, 0, -1);
    checks++;
    if (bus.frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL wrap: got %0d, expected 0", bus.frame_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_restart_ignored();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
